// File: rtl/mac_acc_drain.sv
// Drains a double-buffered 4-lane accumulator snapshot as four tagged words over valid/ready.
// Output valid rises one cycle after capture; snapshots hand over back to back with no bubble.
module mac_acc_drain #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      cap_valid,
  output logic                      cap_ready,
  input  logic [MAC_ACC_WIDTH-1:0]  in0,
  input  logic [MAC_ACC_WIDTH-1:0]  in1,
  input  logic [MAC_ACC_WIDTH-1:0]  in2,
  input  logic [MAC_ACC_WIDTH-1:0]  in3,
  output logic [MAC_ACC_WIDTH-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_idx,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      out_end,
  output logic                      out_acc,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_QUAD   = 2'b10;

  logic [3:0][MAC_ACC_WIDTH-1:0] a_lane_q, a_lane_d, b_lane_q, b_lane_d;
  logic [1:0] a_mode_q, a_mode_d, b_mode_q, b_mode_d;
  logic       a_acc_q, a_acc_d, b_acc_q, b_acc_d;
  logic       a_full_q, a_full_d, b_full_q, b_full_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic [3:0][MAC_ACC_WIDTH-1:0] in_lanes;
  logic xfer, a_done, cap, drop;

  assign in_lanes = {in3, in2, in1, in0};

  always_comb begin
    a_lane_d = a_lane_q;
    a_mode_d = a_mode_q;
    a_acc_d  = a_acc_q;
    a_full_d = a_full_q;
    b_lane_d = b_lane_q;
    b_mode_d = b_mode_q;
    b_acc_d  = b_acc_q;
    b_full_d = b_full_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    xfer   = a_full_q && out_ready;
    a_done = xfer && (cnt_q == 2'd3);
    cap    = cap_valid && !b_full_q;
    drop   = cap_valid && b_full_q;

    if (xfer) begin
      cnt_d = cnt_q + 2'd1;
    end

    if (a_done) begin
      if (b_full_q) begin
        a_lane_d = b_lane_q;
        a_mode_d = b_mode_q;
        a_acc_d  = b_acc_q;
        b_full_d = 1'b0;
      end else begin
        a_full_d = 1'b0;
      end
    end

    // A capture can only happen with B empty, so it never collides with the B->A move.
    if (cap) begin
      if (!a_full_q || a_done) begin
        a_lane_d = in_lanes;
        a_mode_d = cfg[1:0];
        a_acc_d  = cfg[2];
        a_full_d = 1'b1;
      end else begin
        b_lane_d = in_lanes;
        b_mode_d = cfg[1:0];
        b_acc_d  = cfg[2];
        b_full_d = 1'b1;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lane_q <= '0;
      a_mode_q <= '0;
      a_acc_q  <= 1'b0;
      a_full_q <= 1'b0;
      b_lane_q <= '0;
      b_mode_q <= '0;
      b_acc_q  <= 1'b0;
      b_full_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      a_lane_q <= a_lane_d;
      a_mode_q <= a_mode_d;
      a_acc_q  <= a_acc_d;
      a_full_q <= a_full_d;
      b_lane_q <= b_lane_d;
      b_mode_q <= b_mode_d;
      b_acc_q  <= b_acc_d;
      b_full_q <= b_full_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cap_ready = !b_full_q;
  assign out_valid = a_full_q;
  assign ovf       = ovf_q;

  // Data and tags read zero whenever nothing is being offered, including after reset.
  always_comb begin
    out_data  = '0;
    out_idx   = 2'd0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_end   = 1'b0;
    out_acc   = 1'b0;
    if (a_full_q) begin
      out_data = a_lane_q[cnt_q];
      out_end  = (cnt_q == 2'd3);
      out_acc  = a_acc_q;
      if (a_mode_q == MODE_SINGLE) begin
        out_idx   = cnt_q;
        out_first = 1'b1;
        out_last  = 1'b1;
      end else if (a_mode_q == MODE_QUAD) begin
        out_idx   = 2'd0;
        out_first = (cnt_q == 2'd0);
        out_last  = (cnt_q == 2'd3);
      end else begin
        out_idx   = {1'b0, cnt_q[1]};
        out_first = ~cnt_q[0];
        out_last  = cnt_q[0];
      end
    end
  end

endmodule
